meatsquare_drawer: RTL and testbench

Animates one falling "meatsquare" sprite on the 160x120, 3-bit-colour VGA frame. Each `go` tick from the frame-rate delay counter erases the square at its old position, moves it down, and redraws it at the new position. It emits one pixel per cycle as `x`/`y`/`color`/`plot` for the VGA adapter, and sits downstream of the delay counter and control FSM, alongside `sky`.

---
 rtl/game_pkg.sv | 21 ++
 rtl/square_scanner.sv | 42 ++++
 rtl/meatsquare_drawer.sv | 159 +++++++++++++++
 tb/tb_meatsquare_drawer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared screen constants and pass-state encoding for the falling-square game blocks.
package game_pkg;

    localparam int         SCREEN_W    = 160;
    localparam int         SCREEN_H    = 120;
    localparam logic [2:0] COLOR_BLACK = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_DRAW,
        S_DONE
    } draw_state_t;

    // Keep a spawn column far enough left that the whole square stays on screen.
    function automatic logic [7:0] clamp_x(input logic [7:0] xs, input logic [7:0] limit);
        return (xs > limit) ? limit : xs;
    endfunction

endpackage

// File: rtl/square_scanner.sv
// Row-major pixel counter for one SIZE x SIZE square.
// ox/oy are look-ahead offsets: they show the value cnt takes after the next edge.
// This lets the parent register each pixel in the same cycle its state is entered.
module square_scanner #(
    parameter int LOG_SIZE = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    output logic [LOG_SIZE-1:0] ox,
    output logic [LOG_SIZE-1:0] oy,
    output logic                last
);

    localparam int CNT_W = 2 * LOG_SIZE;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance (wrapping to 0 after the last pixel).
    always_comb begin
        cnt_d = cnt;
        if (clear)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_d;
    end

    assign ox   = cnt_d[LOG_SIZE-1:0];
    assign oy   = cnt_d[CNT_W-1:LOG_SIZE];
    assign last = &cnt;

endmodule

// File: rtl/meatsquare_drawer.sv
// Erase / move / redraw of one falling square, one registered pixel per cycle.
// The state register is aligned with the registered outputs: every output is
// computed from the next state and next position and loaded on the same edge.
module meatsquare_drawer
    import game_pkg::*;
#(
    parameter int         SIZE   = 4,
    parameter logic [2:0] COLOR  = 3'b100,
    parameter int         Y_STEP = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       respawn,
    input  logic [7:0] x_start,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       busy,
    output logic       landed,
    output logic       finish_drawing
);

    localparam int         LOG_SIZE = $clog2(SIZE);
    localparam logic [7:0] X_LIMIT  = 8'(SCREEN_W - SIZE);
    localparam logic [6:0] Y_FLOOR  = 7'(SCREEN_H - SIZE);
    localparam logic [7:0] Y_STEP8  = 8'(Y_STEP);

    draw_state_t state, state_d;

    logic [7:0] pos_x, pos_x_d;
    logic [6:0] pos_y, pos_y_d;
    logic       valid, valid_d;
    logic       armed, armed_d;
    logic       landed_d;
    logic [7:0] y_sum;

    logic                scan_en;
    logic                scan_last;
    logic [LOG_SIZE-1:0] ox, oy;

    logic scanning_d;
    logic busy_d;

    // The counter only runs while pixels are emitted; every other state parks it at 0,
    // so entering ERASE or DRAW always starts from the top-left pixel.
    assign scan_en = (state == S_ERASE) || (state == S_DRAW);

    square_scanner #(
        .LOG_SIZE (LOG_SIZE)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (!scan_en),
        .enable (scan_en),
        .ox     (ox),
        .oy     (oy),
        .last   (scan_last)
    );

    // Next-state, position and flag logic.
    always_comb begin
        state_d  = state;
        pos_x_d  = pos_x;
        pos_y_d  = pos_y;
        valid_d  = valid;
        armed_d  = armed;
        landed_d = landed;
        // 8-bit sum so a step near the bottom cannot wrap past row 127.
        y_sum    = {1'b0, pos_y} + Y_STEP8;

        case (state)
            S_IDLE: begin
                if (respawn) begin
                    pos_x_d  = clamp_x(x_start, X_LIMIT);
                    pos_y_d  = '0;
                    valid_d  = 1'b0;
                    armed_d  = 1'b0;
                    landed_d = 1'b0;
                end else if (go && !landed) begin
                    state_d = valid ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE: begin
                if (scan_last)
                    state_d = S_MOVE;
            end
            S_MOVE: begin
                if (y_sum >= {1'b0, Y_FLOOR}) begin
                    pos_y_d = Y_FLOOR;
                    armed_d = 1'b1;
                end else begin
                    pos_y_d = y_sum[6:0];
                end
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (scan_last) begin
                    state_d = S_DONE;
                    // Flags change on the edge into DONE so landed rises with finish_drawing.
                    valid_d = 1'b1;
                    if (armed)
                        landed_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign scanning_d = (state_d == S_ERASE) || (state_d == S_DRAW);
    assign busy_d     = (state_d == S_ERASE) || (state_d == S_MOVE) || (state_d == S_DRAW);

    // State, position and flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            pos_x  <= '0;
            pos_y  <= '0;
            valid  <= 1'b0;
            armed  <= 1'b0;
            landed <= 1'b0;
        end else begin
            state  <= state_d;
            pos_x  <= pos_x_d;
            pos_y  <= pos_y_d;
            valid  <= valid_d;
            armed  <= armed_d;
            landed <= landed_d;
        end
    end

    // Registered pixel and status outputs for the cycle being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            x              <= '0;
            y              <= '0;
            color          <= COLOR_BLACK;
            plot           <= 1'b0;
            busy           <= 1'b0;
            finish_drawing <= 1'b0;
        end else begin
            plot           <= scanning_d;
            busy           <= busy_d;
            finish_drawing <= (state_d == S_DONE);
            color          <= (state_d == S_DRAW) ? COLOR : COLOR_BLACK;
            if (scanning_d) begin
                x <= pos_x_d + 8'(ox);
                y <= pos_y_d + 7'(oy);
            end
        end
    end

endmodule

// File: tb/tb_meatsquare_drawer.sv
// Randomized self-checking bench: a per-pass pixel/status trace is predicted from
// the square's position and flags and compared cycle by cycle.
module tb_meatsquare_drawer;

    localparam int         SZ     = 4;
    localparam logic [2:0] COL    = 3'b100;
    localparam int         YSTEP  = 1;
    localparam int         S2     = SZ * SZ;
    localparam int         FLOOR  = 120 - SZ;
    localparam int         XLIM   = 160 - SZ;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       respawn = 1'b0;
    logic [7:0] x_start = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot, busy, landed, finish_drawing;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the square.
    int m_x = 0;
    int m_y = 0;
    bit m_valid  = 1'b0;
    bit m_landed = 1'b0;

    meatsquare_drawer #(.SIZE(SZ), .COLOR(COL), .Y_STEP(YSTEP)) dut (
        .clock          (clock),
        .reset          (reset),
        .go             (go),
        .respawn        (respawn),
        .x_start        (x_start),
        .x              (x),
        .y              (y),
        .color          (color),
        .plot           (plot),
        .busy           (busy),
        .landed         (landed),
        .finish_drawing (finish_drawing)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pix(input int px, input int py, input logic [2:0] c);
        return {13'b0, 1'b1, 8'(px), 7'(py), c};
    endfunction

    function automatic logic [31:0] obs_pix();
        return plot ? {13'b0, 1'b1, x, y, color} : 32'h0;
    endfunction

    function automatic logic [31:0] obs_all();
        return {10'b0, x, y, color, plot, busy, landed, finish_drawing};
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_valid = 1'b0; m_landed = 1'b0;
    endtask

    task automatic do_respawn(input int xs);
        x_start = 8'(xs);
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        m_x = (xs > XLIM) ? XLIM : xs;
        m_y = 0; m_valid = 1'b0; m_landed = 1'b0;
        chk("respawn_landed", {31'b0, landed}, 32'h0);
    endtask

    // No pixels and no busy for n cycles; landed must hold its modelled value.
    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle", {29'b0, plot, busy, landed}, {29'b0, 1'b0, 1'b0, m_landed});
            step();
        end
    endtask

    // One accepted go: trace every cycle up to finish_drawing.
    // inj_k: cycle at which a stray go is pulsed (0 = none); rst_k: cycle after which reset hits.
    task automatic run_pass(input int inj_k, input int rst_k);
        int old_y, new_y, len, idx;
        bit land, aborted;
        logic [31:0] ep, es;
        aborted = 1'b0;
        old_y   = m_y;
        land    = m_valid && (m_y + YSTEP >= FLOOR);
        new_y   = !m_valid ? m_y : (land ? FLOOR : m_y + YSTEP);
        len     = m_valid ? 2 * S2 + 2 : S2 + 1;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int k = 1; k <= len; k++) begin
            ep = '0;
            es = '0;
            if (m_valid && k <= S2) begin
                idx = k - 1;
                ep  = pix(m_x + idx % SZ, old_y + idx / SZ, 3'b000);
                es  = 32'h4;
            end else if (m_valid && k == S2 + 1) begin
                es  = 32'h4;
            end else if (m_valid && k <= 2 * S2 + 1) begin
                idx = k - S2 - 2;
                ep  = pix(m_x + idx % SZ, new_y + idx / SZ, COL);
                es  = 32'h4;
            end else if (!m_valid && k <= S2) begin
                idx = k - 1;
                ep  = pix(m_x + idx % SZ, m_y + idx / SZ, COL);
                es  = 32'h4;
            end else begin
                es  = {29'b0, 1'b0, 1'b1, land};
            end
            chk("pixel", obs_pix(), ep);
            chk("status", {29'b0, busy, finish_drawing, landed}, es);
            if (k == rst_k) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk("reset_mid_pass", obs_all(), 32'h0);
                model_reset();
                aborted = 1'b1;
                break;
            end
            if (k == inj_k && k < len)
                go = 1'b1;
            step();
            go = 1'b0;
        end
        if (!aborted) begin
            m_y      = new_y;
            m_valid  = 1'b1;
            m_landed = land;
        end
    endtask

    initial begin
        int passes;
        // Reset state
        step();
        chk("reset_state", obs_all(), 32'h0);
        step();
        reset = 1'b0;
        chk("after_reset", obs_all(), 32'h0);

        // First draw at column 40, then a move pass with a stray go mid-erase.
        do_respawn(40);
        run_pass(0, 0);
        run_pass(5, 0);
        chk("pos_after_move", 32'(m_y), 32'd1);
        check_idle(2);

        // Spawn column clamp.
        do_respawn(200);
        chk("clamp_x", 32'(m_x), 32'd156);
        run_pass(0, 0);
        run_pass($urandom_range(1, 33), 0);

        // Random spawn, fall until landing, with random gaps and stray go pulses.
        do_respawn($urandom_range(0, 255));
        passes = 0;
        while (!m_landed && passes < 200) begin
            run_pass(($urandom_range(0, 1) == 1) ? $urandom_range(1, 33) : 0, 0);
            repeat ($urandom_range(0, 3)) step();
            passes++;
        end
        chk("landed_reached", {31'b0, m_landed}, 32'h1);
        chk("landed_row", 32'(m_y), 32'(FLOOR));

        // go while landed is ignored.
        go = 1'b1;
        step();
        go = 1'b0;
        check_idle(40);

        // respawn clears landed.
        do_respawn($urandom_range(0, 255));

        // respawn and go together: respawn wins, no pixels.
        x_start = 8'($urandom_range(0, 255));
        respawn = 1'b1;
        go      = 1'b1;
        m_x     = (int'(x_start) > XLIM) ? XLIM : int'(x_start);
        m_y = 0; m_valid = 1'b0; m_landed = 1'b0;
        step();
        respawn = 1'b0;
        go      = 1'b0;
        check_idle(20);
        run_pass(0, 0);
        run_pass(0, 0);

        // Reset at the 5th draw pixel of a move pass, then a fresh first draw at (0,0).
        run_pass(0, S2 + 2 + 4);
        check_idle(3);
        run_pass(0, 0);
        run_pass($urandom_range(1, 33), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
